// File: rtl/regfile_arb_pkg.sv
// Shared state encoding and sizing helpers for the register-file arbiter.
package regfile_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam int AW_DEF = 5;
  localparam int DW_DEF = 32;

  // Index width for n requesters, never narrower than one bit.
  function automatic int idxWidth(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/regfile_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first eligible request at or after the pointer wins.
module rr_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW   = idxWidth(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [NREQ-1:0] i_mask,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IW-1:0]   o_idx,
  output logic            o_valid
);

  logic [NREQ-1:0] w_eligible;
  logic [NREQ-1:0] w_rotated;
  logic [IW:0]     w_sum;

  assign w_eligible = i_req & ~i_mask;
  assign w_rotated  = NREQ'({w_eligible, w_eligible} >> i_ptr);

  // Walk downward so the slot closest to the pointer is assigned last and wins.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    o_grant = '0;
    w_sum   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_rotated[k]) begin
        o_valid = 1'b1;
        w_sum   = {1'b0, i_ptr} + (IW+1)'(k);
        if (w_sum >= (IW+1)'(NREQ)) w_sum = w_sum - (IW+1)'(NREQ);
        o_idx = w_sum[IW-1:0];
      end
    end
    if (o_valid) o_grant = NREQ'(1) << o_idx;
  end

endmodule

// File: rtl/regfile_arbiter.sv
// Serialises NREQ requesters onto a register file that does one write or one
// registered dual read per clock, with round-robin fairness and req/ack handshakes.
module regfile_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int  NREQ = 2,
  parameter int  AW   = AW_DEF,
  parameter int  DW   = DW_DEF,
  localparam int IW   = idxWidth(NREQ)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NREQ-1:0]    i_req,
  input  logic [NREQ-1:0]    i_we,
  input  logic [NREQ*AW-1:0] i_addr1,
  input  logic [NREQ*AW-1:0] i_addr2,
  input  logic [NREQ*DW-1:0] i_wdata,
  output logic [NREQ-1:0]    o_ack,
  output logic [DW-1:0]      o_rdata1,
  output logic [DW-1:0]      o_rdata2,
  output logic               o_busy,
  output logic [IW-1:0]      o_grant_id,
  output logic [15:0]        o_ops_done,
  output logic               o_rf_wr,
  output logic [AW-1:0]      o_rf_r1,
  output logic [AW-1:0]      o_rf_r2,
  output logic [AW-1:0]      o_rf_rd,
  output logic [DW-1:0]      o_rf_wdata,
  input  logic [DW-1:0]      i_rf_out1,
  input  logic [DW-1:0]      i_rf_out2
);

  arb_state_t      r_state;
  arb_state_t      w_nextState;
  logic [IW-1:0]   r_ptr;
  logic            r_we;
  logic [NREQ-1:0] r_ack;
  logic [DW-1:0]   r_rdata1;
  logic [DW-1:0]   r_rdata2;
  logic            r_busy;
  logic [IW-1:0]   r_grantId;
  logic [15:0]     r_opsDone;
  logic            r_rfWr;
  logic [AW-1:0]   r_rfR1;
  logic [AW-1:0]   r_rfR2;
  logic [AW-1:0]   r_rfRd;
  logic [DW-1:0]   r_rfWdata;

  logic [NREQ-1:0] w_grant;
  logic [IW-1:0]   w_idx;
  logic            w_valid;
  logic            w_selWe;
  logic [AW-1:0]   w_selAddr1;
  logic [AW-1:0]   w_selAddr2;
  logic [DW-1:0]   w_selWdata;

  // The ack register doubles as the one-cycle mask: it is high exactly in the
  // IDLE cycle after RESP, so a requester still holding a stale req is skipped.
  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rrArbiter (
    .i_req   (i_req),
    .i_mask  (r_ack),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_valid (w_valid)
  );

  always_comb begin
    w_selWe    = |(i_we & w_grant);
    w_selAddr1 = '0;
    w_selAddr2 = '0;
    w_selWdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_selAddr1 = i_addr1[i*AW +: AW];
        w_selAddr2 = i_addr2[i*AW +: AW];
        w_selWdata = i_wdata[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_valid) w_nextState = ISSUE;
      ISSUE:   w_nextState = r_we ? RESP : WAIT;
      WAIT:    w_nextState = RESP;
      RESP:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr     <= '0;
      r_we      <= 1'b0;
      r_ack     <= '0;
      r_rdata1  <= '0;
      r_rdata2  <= '0;
      r_busy    <= 1'b0;
      r_grantId <= '0;
      r_rfWr    <= 1'b0;
      r_rfR1    <= '0;
      r_rfR2    <= '0;
      r_rfRd    <= '0;
      r_rfWdata <= '0;
    end else begin
      r_ack  <= '0;
      r_busy <= (w_nextState != IDLE);
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_we      <= w_selWe;
            r_grantId <= w_idx;
            r_rfWr    <= w_selWe;
            r_rfRd    <= w_selAddr1;
            r_rfR1    <= w_selAddr1;
            r_rfR2    <= w_selAddr2;
            r_rfWdata <= w_selWdata;
          end
        end
        ISSUE: r_rfWr <= 1'b0;
        WAIT: begin
          r_rdata1 <= i_rf_out1;
          r_rdata2 <= i_rf_out2;
        end
        RESP: begin
          r_ack <= NREQ'(1) << r_grantId;
          r_ptr <= (r_grantId == IW'(NREQ - 1)) ? '0 : r_grantId + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Counts in step with the ack register so the new count is visible with ack.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_opsDone <= '0;
    else          r_opsDone <= r_opsDone + {15'd0, (r_state == RESP)};
  end

  assign o_ack      = r_ack;
  assign o_rdata1   = r_rdata1;
  assign o_rdata2   = r_rdata2;
  assign o_busy     = r_busy;
  assign o_grant_id = r_grantId;
  assign o_ops_done = r_opsDone;
  assign o_rf_wr    = r_rfWr;
  assign o_rf_r1    = r_rfR1;
  assign o_rf_r2    = r_rfR2;
  assign o_rf_rd    = r_rfRd;
  assign o_rf_wdata = r_rfWdata;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter: behavioural register file, expected-ack
// scoreboard and cycle-accurate latency checks.
module tb_regfile_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int IW   = 1;

  typedef struct {
    int            idx;
    logic          isRead;
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    int            ackCyc;
    logic [15:0]   ops;
  } exp_t;

  logic               clk = 1'b0;
  logic               rstN;
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    we;
  logic [NREQ*AW-1:0] addr1;
  logic [NREQ*AW-1:0] addr2;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    ack;
  logic [DW-1:0]      rdata1;
  logic [DW-1:0]      rdata2;
  logic               busy;
  logic [IW-1:0]      grantId;
  logic [15:0]        opsDone;
  logic               rfWr;
  logic [AW-1:0]      rfR1;
  logic [AW-1:0]      rfR2;
  logic [AW-1:0]      rfRd;
  logic [DW-1:0]      rfWdata;
  logic [DW-1:0]      rfOut1;
  logic [DW-1:0]      rfOut2;

  logic [DW-1:0] rfMem [32];
  logic [DW-1:0] shadow [32];
  exp_t          sbQ [$];
  int            total = 0;
  int            bad = 0;
  int            cycleCount = 0;
  int            wrHighCount = 0;
  int            lastWrCycle = -1;
  logic [AW-1:0] lastWrAddr = '0;
  logic [DW-1:0] lastWrData = '0;
  logic [15:0]   modelOps;
  logic [DW-1:0] lastRd1;
  logic [DW-1:0] lastRd2;

  regfile_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .i_clk      (clk),
    .i_rst_n    (rstN),
    .i_req      (req),
    .i_we       (we),
    .i_addr1    (addr1),
    .i_addr2    (addr2),
    .i_wdata    (wdata),
    .o_ack      (ack),
    .o_rdata1   (rdata1),
    .o_rdata2   (rdata2),
    .o_busy     (busy),
    .o_grant_id (grantId),
    .o_ops_done (opsDone),
    .o_rf_wr    (rfWr),
    .o_rf_r1    (rfR1),
    .o_rf_r2    (rfR2),
    .o_rf_rd    (rfRd),
    .o_rf_wdata (rfWdata),
    .i_rf_out1  (rfOut1),
    .i_rf_out2  (rfOut2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount++;

  // Register file: write and registered dual read both act on the edge.
  always @(posedge clk) begin
    if (!rstN) begin
      for (int i = 0; i < 32; i++) rfMem[i] <= '0;
      rfOut1 <= '0;
      rfOut2 <= '0;
    end else begin
      if (rfWr) rfMem[rfRd] <= rfWdata;
      rfOut1 <= rfMem[rfR1];
      rfOut2 <= rfMem[rfR2];
    end
  end

  always @(negedge clk) begin
    if (rfWr) begin
      wrHighCount++;
      lastWrCycle = cycleCount;
      lastWrAddr  = rfRd;
      lastWrData  = rfWdata;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic reportFail(input string tag);
    total++;
    bad++;
    $error("[TB] FAIL %s observed=none expected=ack", tag);
  endtask

  task automatic checkAllZero(input string pfx);
    checkOutput({pfx, ".ack"},     64'(ack),     64'(0));
    checkOutput({pfx, ".rdata1"},  64'(rdata1),  64'(0));
    checkOutput({pfx, ".rdata2"},  64'(rdata2),  64'(0));
    checkOutput({pfx, ".busy"},    64'(busy),    64'(0));
    checkOutput({pfx, ".grant"},   64'(grantId), 64'(0));
    checkOutput({pfx, ".ops"},     64'(opsDone), 64'(0));
    checkOutput({pfx, ".rfWr"},    64'(rfWr),    64'(0));
    checkOutput({pfx, ".rfR1"},    64'(rfR1),    64'(0));
    checkOutput({pfx, ".rfR2"},    64'(rfR2),    64'(0));
    checkOutput({pfx, ".rfRd"},    64'(rfRd),    64'(0));
    checkOutput({pfx, ".rfWdata"}, 64'(rfWdata), 64'(0));
  endtask

  task automatic applyStimulus(input int idx, input bit isWrite, input logic [AW-1:0] a1,
                               input logic [AW-1:0] a2, input logic [DW-1:0] wd);
    for (int i = 0; i < NREQ; i++) begin
      if (i == idx) begin
        req[i]            = 1'b1;
        we[i]             = isWrite;
        addr1[i*AW +: AW] = a1;
        addr2[i*AW +: AW] = a2;
        wdata[i*DW +: DW] = wd;
      end
    end
  endtask

  task automatic pushExp(input int idx, input bit isWrite, input logic [AW-1:0] a1,
                         input logic [AW-1:0] a2, input logic [DW-1:0] wd, input int ackCyc);
    exp_t e;
    modelOps   = modelOps + 16'd1;
    e.idx      = idx;
    e.isRead   = !isWrite;
    e.ackCyc   = ackCyc;
    e.ops      = modelOps;
    e.d1       = '0;
    e.d2       = '0;
    if (isWrite) shadow[a1] = wd;
    else begin
      e.d1 = shadow[a1];
      e.d2 = shadow[a2];
    end
    sbQ.push_back(e);
  endtask

  task automatic serviceAcks(input int count, input bit dropReq);
    exp_t e;
    int   waited;
    for (int k = 0; k < count; k++) begin
      waited = 0;
      do begin
        @(negedge clk);
        waited++;
      end while (ack == '0 && waited < 40);
      if (ack == '0) begin
        reportFail("ackWait");
        return;
      end
      if (sbQ.size() == 0) begin
        reportFail("unexpectedAck");
        return;
      end
      e = sbQ.pop_front();
      if (e.isRead) begin
        lastRd1 = e.d1;
        lastRd2 = e.d2;
      end
      checkOutput("ackVector", 64'(ack),        64'(NREQ'(1) << e.idx));
      checkOutput("ackCycle",  64'(cycleCount), 64'(e.ackCyc));
      checkOutput("grantId",   64'(grantId),    64'(e.idx));
      checkOutput("opsDone",   64'(opsDone),    64'(e.ops));
      checkOutput("ackBusy",   64'(busy),       64'(0));
      checkOutput("rdata1",    64'(rdata1),     64'(lastRd1));
      checkOutput("rdata2",    64'(rdata2),     64'(lastRd2));
      if (dropReq) req = req & ~(NREQ'(1) << e.idx);
    end
  endtask

  task automatic singleOp(input int idx, input bit isWrite, input logic [AW-1:0] a1,
                          input logic [AW-1:0] a2, input logic [DW-1:0] wd, output int startCyc);
    @(negedge clk);
    startCyc = cycleCount;
    applyStimulus(idx, isWrite, a1, a2, wd);
    pushExp(idx, isWrite, a1, a2, wd, startCyc + (isWrite ? 3 : 4));
    serviceAcks(1, 1'b1);
  endtask

  initial begin
    int n;
    int wr0;
    for (int i = 0; i < 32; i++) shadow[i] = '0;
    modelOps = '0;
    lastRd1  = '0;
    lastRd2  = '0;
    rstN  = 1'b0;
    req   = '0;
    we    = '0;
    addr1 = '0;
    addr2 = '0;
    wdata = '0;

    repeat (2) @(negedge clk);
    checkAllZero("reset");
    rstN = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("idleBusy", 64'(busy), 64'(0));
    end

    $display("[TB] single write then read");
    wr0 = wrHighCount;
    singleOp(0, 1'b1, 5'd5, 5'd0, 32'hDEADBEEF, n);
    checkOutput("wrPulses", 64'(wrHighCount - wr0), 64'(1));
    checkOutput("wrCycle",  64'(lastWrCycle),       64'(n + 1));
    checkOutput("wrAddr",   64'(lastWrAddr),        64'(5));
    checkOutput("wrData",   64'(lastWrData),        64'(32'hDEADBEEF));
    wr0 = wrHighCount;
    singleOp(0, 1'b0, 5'd5, 5'd0, 32'h0, n);
    checkOutput("readNoWr", 64'(wrHighCount - wr0), 64'(0));

    $display("[TB] dual read");
    singleOp(0, 1'b1, 5'd3, 5'd0, 32'h11, n);
    singleOp(0, 1'b1, 5'd7, 5'd0, 32'h22, n);
    singleOp(0, 1'b0, 5'd3, 5'd7, 32'h0, n);

    $display("[TB] contention with pointer at 1");
    @(negedge clk);
    n = cycleCount;
    applyStimulus(1, 1'b1, 5'd9, 5'd0, 32'hA5);
    applyStimulus(0, 1'b0, 5'd9, 5'd9, 32'h0);
    pushExp(1, 1'b1, 5'd9, 5'd0, 32'hA5, n + 3);
    pushExp(0, 1'b0, 5'd9, 5'd9, 32'h0, n + 7);
    serviceAcks(2, 1'b1);

    $display("[TB] round robin with both requests held");
    @(negedge clk);
    n = cycleCount;
    applyStimulus(0, 1'b1, 5'd10, 5'd0, 32'h100);
    applyStimulus(1, 1'b1, 5'd11, 5'd0, 32'h200);
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) pushExp(1, 1'b1, 5'd11, 5'd0, 32'h200, n + 3 + 3*i);
      else            pushExp(0, 1'b1, 5'd10, 5'd0, 32'h100, n + 3 + 3*i);
    end
    serviceAcks(4, 1'b0);
    req = '0;

    $display("[TB] single requester back to back");
    @(negedge clk);
    n = cycleCount;
    applyStimulus(0, 1'b1, 5'd12, 5'd0, 32'hCAFE0001);
    for (int i = 0; i < 3; i++) pushExp(0, 1'b1, 5'd12, 5'd0, 32'hCAFE0001, n + 3 + 4*i);
    serviceAcks(3, 1'b0);
    req = '0;
    singleOp(0, 1'b0, 5'd12, 5'd11, 32'h0, n);

    $display("[TB] op counter wrap");
    // Jump the op counter near its wrap point instead of issuing 65k ops.
    @(negedge clk);
    force dut.r_opsDone = 16'hFFFE;
    repeat (2) @(negedge clk);
    release dut.r_opsDone;
    modelOps = 16'hFFFE;
    singleOp(1, 1'b1, 5'd20, 5'd0, 32'h12345678, n);
    singleOp(0, 1'b1, 5'd21, 5'd0, 32'h9ABCDEF0, n);
    singleOp(1, 1'b0, 5'd20, 5'd21, 32'h0, n);

    $display("[TB] reset during ISSUE");
    @(negedge clk);
    applyStimulus(0, 1'b1, 5'd22, 5'd0, 32'h77);
    @(negedge clk);
    checkOutput("issueWr", 64'(rfWr), 64'(1));
    #1 rstN = 1'b0;
    #1 checkAllZero("midReset");
    req = '0;
    @(negedge clk);
    rstN = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("postRstBusy", 64'(busy), 64'(0));
      checkOutput("postRstAck",  64'(ack),  64'(0));
    end
    checkOutput("sbEmpty", 64'(sbQ.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
